// File: rtl/door_motor_scheduler.sv
// ============================================================================
// door_motor_scheduler
// ----------------------------------------------------------------------------
// Shares one door-motor driver between N_DOORS door controllers.
//
// Arbitration is round-robin. Urgent (obstacle) requests are served first and
// may preempt a non-urgent owner. A motor-off cooldown of COOLDOWN cycles
// separates successive owners.
//
// Optional feature, selected by the macro MAX_RUN_TIMEOUT_EN:
//   defined   - a grant is force-released after MAX_RUN cycles and timeout
//               pulses for one cycle.
//   undefined - a grant is unbounded and timeout is held at 0.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active low
//   req        in   N_DOORS  level request per door
//   urgent     in   N_DOORS  obstacle flag per door (qualified by req)
//   gnt        out  N_DOORS  one-hot grant, all-zero when there is no owner
//   motor_en   out  1        motor driver enable (= |gnt)
//   motor_sel  out  3        index of the current owner, 0 when idle
//   busy       out  1        high in GRANT or COOLDOWN
//   timeout    out  1        one-cycle pulse on a forced release
// ============================================================================
module door_motor_scheduler #(
    parameter int N_DOORS  = 4,
    parameter int COOLDOWN = 3,
    parameter int MAX_RUN  = 50,
    parameter int CW       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DOORS-1:0] req,
    input  logic [N_DOORS-1:0] urgent,
    output logic [N_DOORS-1:0] gnt,
    output logic               motor_en,
    output logic [2:0]         motor_sel,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Round-robin pick: returns {found, index} of the first set bit of vec,
    // scanning upward from ptr with wrap. The loop runs from the farthest
    // offset down so that the nearest hit is the one left standing.
    function automatic logic [3:0] rr_pick(input logic [N_DOORS-1:0] vec,
                                           input logic [2:0]         ptr);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int i = N_DOORS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_DOORS) begin
                idx = idx - N_DOORS;
            end
            if (vec[idx]) begin
                res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

    // Pointer to the door just after the winner, wrapping at N_DOORS.
    function automatic logic [2:0] next_ptr(input logic [2:0] win);
        int n;
        n = int'(win) + 1;
        if (n >= N_DOORS) begin
            n = 0;
        end
        return 3'(n);
    endfunction

    function automatic logic [N_DOORS-1:0] one_hot(input logic [2:0] idx);
        logic [N_DOORS-1:0] v;
        v      = {N_DOORS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [N_DOORS-1:0] gnt_r, gnt_s;
    logic [2:0]         sel_r, sel_s;
    logic               busy_r, busy_s;
    logic               en_r;
    logic               timeout_r, timeout_s;
    logic [2:0]         rr_ptr_r, rr_ptr_s;
    logic [CW-1:0]      cd_cnt_r, cd_cnt_s;
`ifdef MAX_RUN_TIMEOUT_EN
    logic [CW-1:0]      run_cnt_r, run_cnt_s;
`endif

    logic [N_DOORS-1:0] eff_urg_s;
    logic [N_DOORS-1:0] owner_mask_s;
    logic [3:0]         pick_urg_s, pick_req_s;
    logic               win_valid_s;
    logic [2:0]         win_idx_s;
    logic               owner_req_s, owner_urg_s, other_urg_s;
    logic               expired_s;

    // Request qualification and arbitration candidates. During GRANT the
    // owner index is carried in sel_r.
    always_comb begin
        eff_urg_s    = req & urgent;
        owner_mask_s = one_hot(sel_r);
        pick_urg_s   = rr_pick(eff_urg_s, rr_ptr_r);
        pick_req_s   = rr_pick(req, rr_ptr_r);
        win_valid_s  = pick_urg_s[3] | pick_req_s[3];
        if (pick_urg_s[3]) begin
            win_idx_s = pick_urg_s[2:0];
        end else begin
            win_idx_s = pick_req_s[2:0];
        end
        owner_req_s = |(req & owner_mask_s);
        owner_urg_s = |(eff_urg_s & owner_mask_s);
        other_urg_s = |(eff_urg_s & ~owner_mask_s);
`ifdef MAX_RUN_TIMEOUT_EN
        expired_s   = (run_cnt_r == CW'(MAX_RUN - 1));
`else
        expired_s   = 1'b0;
`endif
    end

    // Next-state and next-output logic for IDLE -> GRANT -> COOLDOWN.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        sel_s     = sel_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        rr_ptr_s  = rr_ptr_r;
        cd_cnt_s  = cd_cnt_r;
`ifdef MAX_RUN_TIMEOUT_EN
        run_cnt_s = run_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_s  = ST_GRANT;
                    gnt_s    = one_hot(win_idx_s);
                    sel_s    = win_idx_s;
                    busy_s   = 1'b1;
                    rr_ptr_s = next_ptr(win_idx_s);
`ifdef MAX_RUN_TIMEOUT_EN
                    run_cnt_s = {CW{1'b0}};
`endif
                end else begin
                    gnt_s  = {N_DOORS{1'b0}};
                    sel_s  = 3'd0;
                    busy_s = 1'b0;
                end
            end
            ST_GRANT: begin
                // Release, preemption of a non-urgent owner, or run expiry.
                // A release that coincides with a new urgent request is
                // simply a release.
                if (!owner_req_s || (!owner_urg_s && other_urg_s) || expired_s) begin
                    gnt_s     = {N_DOORS{1'b0}};
                    sel_s     = 3'd0;
                    timeout_s = expired_s & owner_req_s;
                    cd_cnt_s  = {CW{1'b0}};
                    if (COOLDOWN == 0) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_COOLDOWN;
                        busy_s  = 1'b1;
                    end
                end else begin
`ifdef MAX_RUN_TIMEOUT_EN
                    run_cnt_s = run_cnt_r + CW'(1);
`endif
                    busy_s = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_r == CW'(COOLDOWN - 1)) begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    cd_cnt_s = {CW{1'b0}};
                end else begin
                    cd_cnt_s = cd_cnt_r + CW'(1);
                    busy_s   = 1'b1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                gnt_s    = {N_DOORS{1'b0}};
                sel_s    = 3'd0;
                busy_s   = 1'b0;
                cd_cnt_s = {CW{1'b0}};
            end
        endcase
    end

    // State and registered-output flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= {N_DOORS{1'b0}};
            sel_r     <= 3'd0;
            busy_r    <= 1'b0;
            en_r      <= 1'b0;
            timeout_r <= 1'b0;
            rr_ptr_r  <= 3'd0;
            cd_cnt_r  <= {CW{1'b0}};
`ifdef MAX_RUN_TIMEOUT_EN
            run_cnt_r <= {CW{1'b0}};
`endif
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            sel_r     <= sel_s;
            busy_r    <= busy_s;
            en_r      <= |gnt_s;
            timeout_r <= timeout_s;
            rr_ptr_r  <= rr_ptr_s;
            cd_cnt_r  <= cd_cnt_s;
`ifdef MAX_RUN_TIMEOUT_EN
            run_cnt_r <= run_cnt_s;
`endif
        end
    end

    assign gnt       = gnt_r;
    assign motor_en  = en_r;
    assign motor_sel = sel_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule
